pipe_ctrl: RTL

Central sequencing controller for the 5-stage pipeline. It owns the write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It tracks a valid bit per stage so it can resolve load-use stalls, taken-branch redirects, data-memory wait states and halt draining. It also produces the retire pulse and retired-instruction count that the WB stage consumes.

---
 rtl/pipe_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Central sequencing controller for a 5-stage pipeline (IF, ID, EX, MEM, WB).
//   It keeps a valid bit for each of the ID, EX, MEM and WB stages, plus halt
//   markers for EX, MEM and WB. From these bits and the hazard inputs it drives
//   the write enables, flushes and bubble insertion for the pipeline registers.
//   It also produces the retire pulse and the retired-instruction count.
//
// Parameters
//   CNT_W           width of the retired-instruction counter (wraps silently)
//
// Ports
//   CLK             sole clock, posedge
//   RST             synchronous, active-high reset
//   ID_LOAD_USE     instruction in ID depends on the load in EX (needs v_id)
//   EX_REDIRECT     taken branch/jump in EX (needs v_ex)
//   ID_HALT         instruction in ID is a halt (needs v_id)
//   MEM_BUSY        data memory not ready: the whole pipeline freezes
//   PC_WE           PC load enable
//   IFID_WE         IF/ID load enable
//   IFID_FLUSH      clear IF/ID to a NOP on this edge
//   IDEX_FLUSH      load an all-zero-control bubble into ID/EX on this edge
//   PIPE_WE         load enable for ID/EX, EX/MEM and MEM/WB
//   WB_VALID        MEM/WB holds a real instruction (gates RF_WE)
//   NUMINSTADD_OUT  one-cycle retire pulse
//   RETIRED         retired-instruction count
//   HALTED          halt has retired, pipeline idle until RST
//   DBG_STATE       current FSM state (0 RUN, 1 DRAIN, 2 HALTED)
//
// Handshake: there is no valid/ready pair here. A hazard input is acted on
// in the same cycle it is high, provided its stage holds a valid
// instruction. MEM_BUSY stalls every stage, and the stalled cycle is not
// counted as a retire.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_LOAD_USE,
  input  logic             EX_REDIRECT,
  input  logic             ID_HALT,
  input  logic             MEM_BUSY,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             PIPE_WE,
  output logic             WB_VALID,
  output logic             NUMINSTADD_OUT,
  output logic [CNT_W-1:0] RETIRED,
  output logic             HALTED,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state;
  logic             v_id, v_ex, v_mem, v_wb;
  logic             h_ex, h_mem, h_wb;
  logic [CNT_W-1:0] retired_q;

  // Event decode in priority order. Only RUN honours the hazard inputs.
  // Each event needs a valid instruction in the stage it refers to.
  logic run_go;
  logic take_redirect;
  logic take_stall;
  logic take_halt;

  always_comb begin
    run_go        = (state == S_RUN) && !MEM_BUSY;
    take_redirect = run_go && EX_REDIRECT && v_ex;
    take_stall    = run_go && !take_redirect && ID_LOAD_USE && v_id;
    take_halt     = run_go && !take_redirect && !take_stall && ID_HALT && v_id;
  end

  // Pipeline control. These are computed without RST. The output stage
  // forces the reset values onto the ports. The internal advance signal
  // therefore stays clean for the counter logic.
  logic pc_we_c, ifid_we_c, ifid_flush_c, idex_flush_c, pipe_we_c;

  always_comb begin
    pc_we_c      = 1'b0;
    ifid_we_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    pipe_we_c    = 1'b0;
    if (state == S_HALTED || MEM_BUSY) begin
      // frozen: everything stays at zero
    end else if (state == S_DRAIN) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      pipe_we_c    = 1'b1;
    end else if (take_redirect) begin
      pc_we_c      = 1'b1;
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      pipe_we_c    = 1'b1;
    end else if (take_stall) begin
      idex_flush_c = 1'b1;
      pipe_we_c    = 1'b1;
    end else if (take_halt) begin
      ifid_flush_c = 1'b1;
      pipe_we_c    = 1'b1;
    end else begin
      pc_we_c      = 1'b1;
      ifid_we_c    = 1'b1;
      pipe_we_c    = 1'b1;
    end
  end

  // An instruction retires when WB is valid and the pipeline advances.
  // A WB entry held by MEM_BUSY is therefore counted only once.
  logic retire;
  assign retire = v_wb && pipe_we_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      v_id      <= 1'b0;
      v_ex      <= 1'b0;
      v_mem     <= 1'b0;
      v_wb      <= 1'b0;
      h_ex      <= 1'b0;
      h_mem     <= 1'b0;
      h_wb      <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state == S_HALTED) begin
        v_id  <= 1'b0;
        v_ex  <= 1'b0;
        v_mem <= 1'b0;
        v_wb  <= 1'b0;
        h_ex  <= 1'b0;
        h_mem <= 1'b0;
        h_wb  <= 1'b0;
      end else if (!MEM_BUSY) begin
        // MEM -> WB and the markers shift the same way in every advancing case.
        v_wb  <= v_mem;
        h_wb  <= h_mem;
        h_mem <= h_ex;
        if (state == S_DRAIN) begin
          v_id  <= 1'b0;
          v_ex  <= 1'b0;
          v_mem <= v_ex;
          h_ex  <= 1'b0;
          // The halt is in WB on an advancing edge, so it retires now.
          if (h_wb) state <= S_HALTED;
        end else if (take_redirect) begin
          // Squash the wrong-path ID and EX instructions. The branch
          // itself moves on to MEM.
          v_id  <= 1'b0;
          v_ex  <= 1'b0;
          v_mem <= 1'b1;
          h_ex  <= 1'b0;
        end else if (take_stall) begin
          // ID holds its instruction. A bubble goes into EX.
          v_ex  <= 1'b0;
          v_mem <= v_ex;
          h_ex  <= 1'b0;
        end else if (take_halt) begin
          v_id  <= 1'b0;
          v_ex  <= 1'b1;
          v_mem <= v_ex;
          h_ex  <= 1'b1;
          state <= S_DRAIN;
        end else begin
          v_id  <= 1'b1;
          v_ex  <= v_id;
          v_mem <= v_ex;
          h_ex  <= 1'b0;
        end
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output stage. While RST is high the reset values show immediately,
  // before the first reset edge has cleared the registers.
  always_comb begin
    if (RST) begin
      PC_WE          = 1'b0;
      IFID_WE        = 1'b0;
      IFID_FLUSH     = 1'b1;
      IDEX_FLUSH     = 1'b1;
      PIPE_WE        = 1'b0;
      WB_VALID       = 1'b0;
      NUMINSTADD_OUT = 1'b0;
      RETIRED        = '0;
      HALTED         = 1'b0;
    end else begin
      PC_WE          = pc_we_c;
      IFID_WE        = ifid_we_c;
      IFID_FLUSH     = ifid_flush_c;
      IDEX_FLUSH     = idex_flush_c;
      PIPE_WE        = pipe_we_c;
      WB_VALID       = v_wb;
      NUMINSTADD_OUT = retire;
      RETIRED        = retired_q;
      HALTED         = (state == S_HALTED);
    end
  end

  assign DBG_STATE = state;

endmodule
